// File: rtl/ctrl_drain_fifo_if.sv
// Handshake bundle for ctrl_drain_fifo.
// The upstream delay line and the downstream consumer together form the
// master side. The FIFO itself is the slave side.
interface ctrl_drain_fifo_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    logic                       in_valid;
    logic [WIDTH-1:0]           in;
    logic [WIDTH-1:0]           out;
    logic                       out_valid;
    logic                       out_ready;
    logic                       stop;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       overflow;

    modport master (
        output in_valid, in, out_ready,
        input  out, out_valid, stop, count, overflow
    );

    modport slave (
        input  in_valid, in, out_ready,
        output out, out_valid, stop, count, overflow
    );
endinterface

// File: rtl/ctrl_drain_fifo.sv
// ctrl_drain_fifo: elastic buffer at the receiving end of the fixed-latency
// control delay line. It absorbs a non-stallable push stream into a
// (DEPTH-1)-entry circular memory plus one registered output stage, and it
// presents the words downstream with a valid/ready handshake. The stop output
// leaves LENGTH words of headroom for the words still in flight upstream.
module ctrl_drain_fifo #(
    parameter int WIDTH  = 32,
    parameter int LENGTH = 5,
    parameter int DEPTH  = 16
) (
    input  logic             clk,
    input  logic             rst,
    ctrl_drain_fifo_if.slave bus
);
    localparam int MEM_DEPTH = DEPTH - 1;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);
    localparam int PTR_W     = $clog2(MEM_DEPTH) + 1;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STOP_LEVEL = CNT_W'(DEPTH - LENGTH);

    logic [WIDTH-1:0] r_mem [0:MEM_DEPTH-1];
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [WIDTH-1:0] r_out;
    logic             r_outValid;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic             w_push;
    logic             w_pop;
    logic             w_load;
    logic             w_memEmpty;
    logic             w_full;
    logic             w_accept;
    logic             w_bypass;
    logic             w_memRead;
    logic             w_memWrite;
    logic [ADDR_W-1:0] w_rdAddr;
    logic [ADDR_W-1:0] w_wrAddr;

    // The memory holds every word except the one in the output register.
    // So the memory is empty exactly when count equals out_valid.
    assign w_push     = bus.in_valid;
    assign w_pop      = r_outValid && bus.out_ready;
    assign w_load     = !r_outValid || w_pop;
    assign w_memEmpty = (r_count == {{(CNT_W-1){1'b0}}, r_outValid});
    assign w_full     = (r_count == FULL_COUNT);
    assign w_accept   = w_push && (!w_full || w_pop);
    assign w_bypass   = w_load && w_memEmpty && w_accept;
    assign w_memRead  = w_load && !w_memEmpty;
    assign w_memWrite = w_accept && !w_bypass;
    assign w_rdAddr   = r_rdPtr[ADDR_W-1:0];
    assign w_wrAddr   = r_wrPtr[ADDR_W-1:0];

    assign bus.out       = r_out;
    assign bus.out_valid = r_outValid;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.stop      = (r_count >= STOP_LEVEL);

    // Storage array. It has no reset, because only the pointers define which entries are live.
    // When the block is full and a push coincides with a pop, the write and the read share an address.
    // The output register still captures the old contents.
    always_ff @(posedge clk) begin
        if (w_memWrite && !rst) begin
            r_mem[w_wrAddr] <= bus.in;
        end
    end

    // Pointers, output stage, occupancy and sticky overflow. Reset discards any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_out      <= '0;
            r_outValid <= 1'b0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_load) begin
                if (!w_memEmpty) begin
                    r_out      <= r_mem[w_rdAddr];
                    r_outValid <= 1'b1;
                end else if (w_push) begin
                    r_out      <= bus.in;
                    r_outValid <= 1'b1;
                end else begin
                    r_outValid <= 1'b0;
                end
            end
            if (w_memRead) begin
                r_rdPtr <= (r_rdPtr == LAST_IDX) ? '0 : r_rdPtr + 1'b1;
            end
            if (w_memWrite) begin
                r_wrPtr <= (r_wrPtr == LAST_IDX) ? '0 : r_wrPtr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
            if (w_push && !w_accept) begin
                r_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ctrl_drain_fifo.sv
// Testbench for ctrl_drain_fifo.
// A queue-based model of the held words runs alongside directed and random
// traffic. Every DUT output is compared with the model after every clock edge.
module tb_ctrl_drain_fifo;
    localparam int WIDTH  = 32;
    localparam int LENGTH = 5;
    localparam int DEPTH  = 16;

    logic clk;
    logic rst;

    ctrl_drain_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    ctrl_drain_fifo #(.WIDTH(WIDTH), .LENGTH(LENGTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    // The model holds every word in the block. Its head is the word shown on out.
    logic [31:0] modelQ[$];
    logic [31:0] modelLastOut = 32'h0;
    bit          modelOverflow = 1'b0;

    function automatic bit modelStop();
        return (DEPTH - modelQ.size()) <= LENGTH;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Compare every DUT output with the model.
    task automatic checkOutput(input string tag);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(modelQ.size() > 0));
        check({tag, ".out"},       bus.out, (modelQ.size() > 0) ? modelQ[0] : modelLastOut);
        check({tag, ".count"},     32'(bus.count), 32'(modelQ.size()));
        check({tag, ".stop"},      32'(bus.stop), 32'(modelStop()));
        check({tag, ".overflow"},  32'(bus.overflow), 32'(modelOverflow));
    endtask

    // Drive one cycle of inputs at the falling edge and step the model at the rising edge.
    // Then check all outputs 1 time unit later.
    task automatic applyStimulus(input bit rstIn, input bit valid, input logic [31:0] data,
                                 input bit ready, input string tag);
        bit pop;
        bit accept;
        @(negedge clk);
        rst           = rstIn;
        bus.in_valid  = valid;
        bus.in        = data;
        bus.out_ready = ready;
        @(posedge clk);
        if (rstIn) begin
            modelQ.delete();
            modelLastOut  = 32'h0;
            modelOverflow = 1'b0;
        end else begin
            pop    = (modelQ.size() > 0) && ready;
            accept = valid && ((modelQ.size() < DEPTH) || pop);
            if (valid && !accept) modelOverflow = 1'b1;
            if (pop) void'(modelQ.pop_front());
            if (accept) modelQ.push_back(data);
            if (modelQ.size() > 0) modelLastOut = modelQ[0];
        end
        #1;
        checkOutput(tag);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (modelQ.size() > 0 && n < 200) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, tag);
            n++;
        end
        check({tag, ".drained"}, 32'(modelQ.size()), 32'd0);
    endtask

    initial begin
        int pushed;
        int cyc;
        logic [31:0] word;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.out_ready = 1'b0;

        // Reset state
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, "reset");
        check("reset.count_const", 32'(bus.count), 32'd0);

        // Single word with 1-cycle latency
        applyStimulus(1'b0, 1'b1, 32'hA5A5_0001, 1'b1, "single");
        check("single.out_const", bus.out, 32'hA5A5_0001);
        check("single.valid_const", 32'(bus.out_valid), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, "single_gone");
        check("single_gone.valid_const", 32'(bus.out_valid), 32'd0);

        // Backpressure fill to the stop threshold, then drain in order
        for (int i = 0; i <= 10; i++) begin
            applyStimulus(1'b0, 1'b1, 32'(i), 1'b0, "fill");
        end
        check("fill.count_const", 32'(bus.count), 32'd11);
        check("fill.stop_const", 32'(bus.stop), 32'd1);
        drain("fill_drain");

        // Overflow: 17 pushes into a 16-word block
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h100 + 32'(i), 1'b0, "ovf");
        end
        check("ovf.overflow_const", 32'(bus.overflow), 32'd1);
        check("ovf.head_const", bus.out, 32'h100);
        drain("ovf_drain");
        check("ovf.sticky_const", 32'(bus.overflow), 32'd1);

        // Full block with simultaneous push and pop
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, "reset2");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h200 + 32'(i), 1'b0, "full_fill");
        end
        for (int i = 16; i < 36; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h200 + 32'(i), 1'b1, "full_pp");
        end
        check("full_pp.count_const", 32'(bus.count), 32'd16);
        check("full_pp.head_const", bus.out, 32'h214);
        drain("full_drain");

        // Reset in the middle of a stream, then a word right after reset
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h300 + 32'(i), 1'b0, "mid_fill");
        end
        applyStimulus(1'b1, 1'b1, 32'h3FF, 1'b1, "mid_reset");
        check("mid_reset.valid_const", 32'(bus.out_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'hBEEF_0001, 1'b1, "after_reset");
        check("after_reset.out_const", bus.out, 32'hBEEF_0001);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, "after_reset_idle");

        // Random traffic through several pointer wraps. Upstream honours stop.
        pushed = 0;
        cyc    = 0;
        while (pushed < 100 && cyc < 3000) begin
            if (($urandom_range(0, 1) == 1) && !modelStop()) begin
                word = $urandom;
                applyStimulus(1'b0, 1'b1, word, bit'($urandom_range(0, 1)), "random");
                pushed++;
            end else begin
                applyStimulus(1'b0, 1'b0, 32'h0, bit'($urandom_range(0, 1)), "random");
            end
            cyc++;
        end
        check("random.pushed", 32'(pushed), 32'd100);
        drain("random_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
